// File: rtl/seq_detect_if.sv
// seq_detect_if: serial input, pattern load and match/status bundle for seq_detect_param
interface seq_detect_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic                         in;
    logic                         en;
    logic                         overlap;
    logic                         pat_ld;
    logic [PAT_W-1:0]             pat_in;
    logic                         tick;
    logic                         match;
    logic [$clog2(PAT_W+1)-1:0]   fill;
    logic [CNT_W-1:0]             match_cnt;
    modport master (output in, en, overlap, pat_ld, pat_in, input tick, match, fill, match_cnt);
    modport slave  (input in, en, overlap, pat_ld, pat_in, output tick, match, fill, match_cnt);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: tick-sampled serial pattern detector with loadable pattern,
// selectable overlap and saturating match counter
module seq_detect_param #(
    parameter int             PAT_W    = 3,
    parameter logic [PAT_W-1:0] PAT_INIT = 3'b001,
    parameter int             DIV      = 50_000_000,
    parameter int             CNT_W    = 8
) (
    input logic        clk,
    input logic        reset,
    seq_detect_if.slave s
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = $clog2(PAT_W + 1);
    logic [DW-1:0]    r_div;
    logic [PAT_W-1:0] r_hist;
    logic [PAT_W-1:0] r_pat;
    logic [FW-1:0]    r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_match;
    logic             w_tick;
    logic [PAT_W-1:0] w_hist;
    logic [FW-1:0]    w_fill;
    logic             w_match;
    // reset gating keeps tick low while held in reset even when DIV=1
    assign w_tick  = s.en && !reset && (r_div == DW'(DIV - 1));
    assign w_hist  = {r_hist[PAT_W-2:0], s.in};
    assign w_fill  = (r_fill == FW'(PAT_W)) ? r_fill : r_fill + 1'b1;
    assign w_match = (w_fill == FW'(PAT_W)) && (w_hist == r_pat);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_hist  <= '0;
            r_pat   <= PAT_INIT;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else if (s.pat_ld) begin
            r_div   <= '0;
            r_hist  <= '0;
            r_pat   <= s.pat_in;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (s.en)
                r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_hist  <= w_hist;
                r_fill  <= (w_match && !s.overlap) ? '0 : w_fill;
                r_match <= w_match;
                if (w_match && r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign s.tick      = w_tick;
    assign s.match     = r_match;
    assign s.fill      = r_fill;
    assign s.match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: DUT a (DIV=4) covers the divider and pat_ld/tick collision,
// DUT b (DIV=1, CNT_W=2) covers detection, overlap, saturation and mid-sequence reset
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int seen = 0;
    bit mon_on = 1'b0;
    bit exp_q[$];
    seq_detect_if #(.PAT_W(3), .CNT_W(8)) a_if ();
    seq_detect_if #(.PAT_W(3), .CNT_W(2)) b_if ();
    seq_detect_param #(.PAT_W(3), .PAT_INIT(3'b001), .DIV(4), .CNT_W(8)) u_a (.clk(clk), .reset(reset), .s(a_if));
    seq_detect_param #(.PAT_W(3), .PAT_INIT(3'b001), .DIV(1), .CNT_W(2)) u_b (.clk(clk), .reset(reset), .s(b_if));
    always #5 clk = ~clk;
    // match scoreboard for DUT b: one expectation per sample edge
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow match=%0b", b_if.match);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (b_if.match !== e) begin
                    bad++;
                    $display("FAIL sb_match got=%0b exp=%0b", b_if.match, e);
                end
            end
            if (b_if.match === 1'b1) seen++;
        end
    end
    task automatic drive_b(input bit v, input bit e);
        b_if.in = v;
        exp_q.push_back(e);
        @(posedge clk); #2;
    endtask
    task automatic load_b(input logic [2:0] p);
        mon_on = 1'b0;
        b_if.pat_ld = 1'b1;
        b_if.pat_in = p;
        @(posedge clk); #2;
        b_if.pat_ld = 1'b0;
        mon_on = 1'b1;
    endtask
    task automatic reset_all();
        mon_on = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
    endtask
    task automatic test_reset();
        reset_all();
        total += 6;
        if (a_if.tick !== 1'b0) begin bad++; $display("FAIL rst_a_tick got=%0b exp=0", a_if.tick); end
        if (b_if.tick !== 1'b0) begin bad++; $display("FAIL rst_b_tick got=%0b exp=0", b_if.tick); end
        if (a_if.match !== 1'b0) begin bad++; $display("FAIL rst_a_match got=%0b exp=0", a_if.match); end
        if (b_if.fill !== 2'd0) begin bad++; $display("FAIL rst_b_fill got=%0d exp=0", b_if.fill); end
        if (a_if.match_cnt !== 8'd0) begin bad++; $display("FAIL rst_a_cnt got=%0d exp=0", a_if.match_cnt); end
        if (b_if.match_cnt !== 2'd0) begin bad++; $display("FAIL rst_b_cnt got=%0d exp=0", b_if.match_cnt); end
        reset = 1'b0;
    endtask
    task automatic test_divider();
        reset_all();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            total++;
            if (a_if.tick !== ((k % 4) == 3)) begin
                bad++;
                $display("FAIL div_tick k=%0d got=%0b exp=%0b", k, a_if.tick, (k % 4) == 3);
            end
        end
        a_if.en = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            total++;
            if (a_if.tick !== 1'b0) begin bad++; $display("FAIL div_hold k=%0d got=%0b exp=0", k, a_if.tick); end
            @(posedge clk); #2;
        end
        a_if.en = 1'b1;
        #1;
        total++;
        if (a_if.tick !== 1'b1) begin bad++; $display("FAIL div_resume got=%0b exp=1", a_if.tick); end
        @(posedge clk); #2;
        total++;
        if (a_if.tick !== 1'b0) begin bad++; $display("FAIL div_wrap got=%0b exp=0", a_if.tick); end
    endtask
    task automatic test_overlap_001();
        bit s[6] = '{0, 0, 1, 0, 0, 1};
        reset_all();
        reset = 1'b0;
        b_if.overlap = 1'b1;
        mon_on = 1'b1;
        for (int i = 0; i < 6; i++) drive_b(s[i], s[i]);
        total += 2;
        if (b_if.match_cnt !== 2'd2) begin bad++; $display("FAIL o001_cnt got=%0d exp=2", b_if.match_cnt); end
        if (b_if.fill !== 2'd3) begin bad++; $display("FAIL o001_fill got=%0d exp=3", b_if.fill); end
    endtask
    task automatic test_pat101(input bit ov);
        bit s[5] = '{1, 0, 1, 0, 1};
        bit e[5];
        e = ov ? '{0, 0, 1, 0, 1} : '{0, 0, 1, 0, 0};
        b_if.overlap = ov;
        load_b(3'b101);
        total++;
        if (b_if.fill !== 2'd0) begin bad++; $display("FAIL p101_ld_fill ov=%0b got=%0d exp=0", ov, b_if.fill); end
        for (int i = 0; i < 5; i++) drive_b(s[i], e[i]);
        total += 2;
        if (b_if.match_cnt !== (ov ? 2'd2 : 2'd1)) begin
            bad++; $display("FAIL p101_cnt ov=%0b got=%0d exp=%0d", ov, b_if.match_cnt, ov ? 2 : 1);
        end
        if (b_if.fill !== (ov ? 2'd3 : 2'd2)) begin
            bad++; $display("FAIL p101_fill ov=%0b got=%0d exp=%0d", ov, b_if.fill, ov ? 3 : 2);
        end
    endtask
    task automatic test_saturate();
        b_if.overlap = 1'b1;
        load_b(3'b001);
        seen = 0;
        for (int g = 0; g < 5; g++) begin
            drive_b(1'b0, 1'b0);
            drive_b(1'b0, 1'b0);
            drive_b(1'b1, 1'b1);
            total++;
            if (b_if.match_cnt !== 2'((g + 1 > 3) ? 3 : g + 1)) begin
                bad++; $display("FAIL sat_cnt g=%0d got=%0d exp=%0d", g, b_if.match_cnt, (g + 1 > 3) ? 3 : g + 1);
            end
        end
        total++;
        if (seen != 5) begin bad++; $display("FAIL sat_pulses got=%0d exp=5", seen); end
    endtask
    task automatic test_reset_mid();
        reset_all();
        reset = 1'b0;
        mon_on = 1'b1;
        drive_b(1'b0, 1'b0);
        drive_b(1'b0, 1'b0);
        mon_on = 1'b0;
        reset = 1'b1;
        b_if.in = 1'b1;
        @(posedge clk); #2;
        total += 3;
        if (b_if.fill !== 2'd0) begin bad++; $display("FAIL rmid_fill got=%0d exp=0", b_if.fill); end
        if (b_if.tick !== 1'b0) begin bad++; $display("FAIL rmid_tick got=%0b exp=0", b_if.tick); end
        if (b_if.match !== 1'b0) begin bad++; $display("FAIL rmid_match got=%0b exp=0", b_if.match); end
        reset = 1'b0;
        mon_on = 1'b1;
        drive_b(1'b1, 1'b0);
        mon_on = 1'b0;
        total++;
        if (b_if.fill !== 2'd1) begin bad++; $display("FAIL rmid_fill_rel got=%0d exp=1", b_if.fill); end
    endtask
    task automatic test_pat_ld_tick();
        reset_all();
        reset = 1'b0;
        a_if.in = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        total += 2;
        if (a_if.tick !== 1'b1) begin bad++; $display("FAIL pltk_align got=%0b exp=1", a_if.tick); end
        if (a_if.fill !== 2'd1) begin bad++; $display("FAIL pltk_pre_fill got=%0d exp=1", a_if.fill); end
        a_if.pat_ld = 1'b1;
        a_if.pat_in = 3'b110;
        @(posedge clk); #2;
        a_if.pat_ld = 1'b0;
        total += 2;
        if (a_if.fill !== 2'd0) begin bad++; $display("FAIL pltk_fill got=%0d exp=0", a_if.fill); end
        if (a_if.match_cnt !== 8'd0) begin bad++; $display("FAIL pltk_cnt got=%0d exp=0", a_if.match_cnt); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            total++;
            if (a_if.tick !== (k == 3)) begin bad++; $display("FAIL pltk_restart k=%0d got=%0b exp=%0b", k, a_if.tick, k == 3); end
        end
    endtask
    initial begin
        a_if.in = 1'b0; a_if.en = 1'b1; a_if.overlap = 1'b1; a_if.pat_ld = 1'b0; a_if.pat_in = '0;
        b_if.in = 1'b0; b_if.en = 1'b1; b_if.overlap = 1'b1; b_if.pat_ld = 1'b0; b_if.pat_in = '0;
        test_reset();
        test_divider();
        test_overlap_001();
        test_pat101(1'b1);
        test_pat101(1'b0);
        test_saturate();
        test_reset_mid();
        test_pat_ld_tick();
        mon_on = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
